// File: rtl/fp_vector_result_buffer_pkg.sv
// Shared vector-format definitions for the FP vector adder and its result buffer.
package fp_pkg;

  localparam int unsigned ELEM_W    = 32;
  localparam int unsigned NUM_ELEMS = 5;
  localparam int unsigned VEC_W     = ELEM_W * NUM_ELEMS;

  typedef logic [VEC_W-1:0] fp_vec_t;

  function automatic logic [ELEM_W-1:0] get_elem(input fp_vec_t v, input int unsigned i);
    return v[i*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/fp_vector_result_buffer_if.sv
// Producer/consumer bundle around the result buffer: issue credit, adder result, consumer handshake.
interface fp_vector_result_buffer_if #(
  parameter int unsigned VEC_W = fp_pkg::VEC_W
) ();

  logic             issue_fire;
  logic             issue_ok;
  logic             in_valid;
  logic [VEC_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_data;

  modport slave (
    input  issue_fire, in_valid, in_data, out_ready,
    output issue_ok, out_valid, out_data
  );

  modport master (
    output issue_fire, in_valid, in_data, out_ready,
    input  issue_ok, out_valid, out_data
  );

endinterface

// File: rtl/fp_vector_result_buffer_fifo_mem.sv
// Register-array storage for the result FIFO: one write port, asynchronous read. Not reset.
module fp_vector_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned VEC_W = 160,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [VEC_W-1:0] rd_data
);

  logic [VEC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fp_vector_result_buffer.sv
// Captures every adder result into a circular FIFO and issues add credits so that
// a slot is guaranteed free when each in-flight result lands.
module fp_vector_result_buffer
  import fp_pkg::*;
#(
  parameter int unsigned  WIDTH      = ELEM_W,
  parameter int unsigned  NUM_INPUTS = NUM_ELEMS,
  parameter int unsigned  DEPTH      = 16,
  parameter int unsigned  LATENCY    = 11,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  fp_vector_result_buffer_if.slave bus,
  output logic [CNT_W-1:0]         occupancy,
  output logic                     err_overflow,
  output logic                     err_credit
);

  localparam int unsigned      VW       = WIDTH * NUM_INPUTS;
  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (DEPTH < 2) begin : g_depth_chk
    $error("fp_vector_result_buffer: DEPTH must be at least 2");
  end
  if (DEPTH < LATENCY + 1) begin : g_rate_chk
    $warning("fp_vector_result_buffer: DEPTH < LATENCY+1, back-to-back issue will stall on credit");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] in_flight, occ_next, in_flight_next;
  logic             out_valid_q, push, pop;
  logic [VW-1:0]    rd_data;

  // Explicit wrap compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop  = out_valid_q & bus.out_ready;
    push = bus.in_valid & ((occupancy < DEPTH_C) | pop);

    occ_next = occupancy;
    if (push && !pop)      occ_next = occupancy + 1'b1;
    else if (!push && pop) occ_next = occupancy - 1'b1;

    // An unmatched result (nothing in flight) leaves the count at zero.
    in_flight_next = in_flight;
    if (bus.issue_fire && !bus.in_valid)                        in_flight_next = in_flight + 1'b1;
    else if (!bus.issue_fire && bus.in_valid && in_flight != '0) in_flight_next = in_flight - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      in_flight    <= '0;
      out_valid_q  <= 1'b0;
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      occupancy   <= occ_next;
      in_flight   <= in_flight_next;
      out_valid_q <= (occ_next != '0);
      if (bus.in_valid && !push)          err_overflow <= 1'b1;
      if (bus.issue_fire && !bus.issue_ok) err_credit   <= 1'b1;
    end
  end

  fp_vector_fifo_mem #(
    .DEPTH (DEPTH),
    .VEC_W (VW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign bus.issue_ok  = ({1'b0, occupancy} + {1'b0, in_flight}) < {1'b0, DEPTH_C};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? rd_data : '0;

endmodule

// File: tb/tb_fp_vector_result_buffer.sv
// Scoreboard bench for fp_vector_result_buffer: a DEPTH=16/LATENCY=11 instance and a DEPTH=5 wrap instance.
module tb_fp_vector_result_buffer;
  import fp_pkg::*;

  typedef struct {
    fp_vec_t data;
    int      cyc_tag;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_vector_result_buffer_if #(.VEC_W(VEC_W)) bus ();
  fp_vector_result_buffer_if #(.VEC_W(VEC_W)) bus5 ();

  logic [4:0] occ;
  logic       ovf, cred;
  logic [2:0] occ5;
  logic       ovf5, cred5;

  fp_vector_result_buffer #(
    .WIDTH(ELEM_W), .NUM_INPUTS(NUM_ELEMS), .DEPTH(16), .LATENCY(11)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .occupancy(occ), .err_overflow(ovf), .err_credit(cred)
  );

  fp_vector_result_buffer #(
    .WIDTH(ELEM_W), .NUM_INPUTS(NUM_ELEMS), .DEPTH(5), .LATENCY(4)
  ) dut5 (
    .clk(clk), .rst(rst), .bus(bus5),
    .occupancy(occ5), .err_overflow(ovf5), .err_credit(cred5)
  );

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    pops = 0;
  int    pops5 = 0;
  item_t exp_q[$];
  item_t exp5_q[$];
  item_t pend_q[$];
  item_t mon_it;

  function automatic fp_vec_t mkvec(input int k);
    fp_vec_t v;
    for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
      if (i == 0) v[i*ELEM_W +: ELEM_W] = ELEM_W'(32'h3F80_0000 + k);
      else        v[i*ELEM_W +: ELEM_W] = ELEM_W'(32'h4000_0000 + (i << 16) + k);
    end
    return v;
  endfunction

  task automatic chk(input string name, input fp_vec_t act, input fp_vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of the main DUT; models the fixed-latency adder via pend_q.
  task automatic cycle(input logic fire, input fp_vec_t fdata, input logic inj,
                       input fp_vec_t idata, input logic ready);
    bus.issue_fire = fire;
    bus.out_ready  = ready;
    if (fire) pend_q.push_back('{fdata, cyc + 11});
    if (pend_q.size() != 0 && pend_q[0].cyc_tag == cyc) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pend_q[0].data;
      void'(pend_q.pop_front());
    end else if (inj) begin
      bus.in_valid = 1'b1;
      bus.in_data  = idata;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic ready);
    cycle(1'b0, '0, 1'b0, '0, ready);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=none", get_elem(bus.out_data, 0));
      end else begin
        mon_it = exp_q.pop_front();
        if (bus.out_data !== mon_it.data || (mon_it.cyc_tag >= 0 && mon_it.cyc_tag != cyc)) begin
          failures++;
          $display("FAIL pop_data elem0 actual=%0h required=%0h cycle actual=%0d required=%0d",
                   get_elem(bus.out_data, 0), get_elem(mon_it.data, 0), cyc, mon_it.cyc_tag);
        end
      end
    end
    if (bus5.out_valid === 1'b1 && bus5.out_ready === 1'b1) begin
      pops5++;
      checks++;
      if (exp5_q.size() == 0) begin
        failures++;
        $display("FAIL wrap_pop_unexpected actual=%0h required=none", get_elem(bus5.out_data, 0));
      end else begin
        mon_it = exp5_q.pop_front();
        if (bus5.out_data !== mon_it.data) begin
          failures++;
          $display("FAIL wrap_pop_data elem0 actual=%0h required=%0h",
                   get_elem(bus5.out_data, 0), get_elem(mon_it.data, 0));
        end
      end
    end
  end

  initial begin
    logic bad_ok, bad_occ, bad_cred;
    int   n, p0, sent;

    bus.issue_fire = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus5.issue_fire = 1'b0; bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_issue_ok", bus.issue_ok, 1);
    chk("rst_occupancy", occ, 0);
    chk("rst_err_overflow", ovf, 0);
    chk("rst_err_credit", cred, 0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst5_issue_ok", bus5.issue_ok, 1);
    rst = 1'b1;
    idle(1'b0);

    // Asynchronous reset with three entries stored
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, mkvec(900 + k), 1'b0);
    idle(1'b0);
    chk("pre_rst_occupancy", occ, 3);
    chk("pre_rst_out_valid", bus.out_valid, 1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_occupancy", occ, 0);
    chk("async_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
    idle(1'b1);

    // Streaming: issue every cycle, results pop the cycle after they land
    bad_ok = 1'b0; bad_occ = 1'b0; p0 = pops;
    for (int k = 0; k < 40; k++) begin
      if (bus.issue_ok !== 1'b1) bad_ok = 1'b1;
      if (occ > 1) bad_occ = 1'b1;
      exp_q.push_back('{mkvec(k), cyc + 12});
      cycle(1'b1, mkvec(k), 1'b0, '0, 1'b1);
    end
    repeat (14) begin
      if (occ > 1) bad_occ = 1'b1;
      idle(1'b1);
    end
    chk("stream_issue_ok_held", bad_ok, 0);
    chk("stream_occ_le1", bad_occ, 0);
    chk("stream_pop_count", pops - p0, 40);
    chk("stream_err_overflow", ovf, 0);
    chk("stream_err_credit", cred, 0);

    // Backpressure: credit runs out at exactly DEPTH adds
    n = 0;
    while (bus.issue_ok === 1'b1 && n < 40) begin
      exp_q.push_back('{mkvec(100 + n), -1});
      cycle(1'b1, mkvec(100 + n), 1'b0, '0, 1'b0);
      n++;
    end
    chk("bp_accepted", n, 16);
    repeat (12) idle(1'b0);
    chk("bp_occ_full", occ, 16);
    chk("bp_issue_ok_low", bus.issue_ok, 0);
    chk("bp_err_overflow", ovf, 0);

    // Full: push with simultaneous pop, then push without pop
    exp_q.push_back('{mkvec(200), -1});
    cycle(1'b0, '0, 1'b1, mkvec(200), 1'b1);
    chk("full_pushpop_occ", occ, 16);
    chk("full_pushpop_err", ovf, 0);
    cycle(1'b0, '0, 1'b1, mkvec(201), 1'b0);
    chk("full_drop_err_overflow", ovf, 1);
    chk("full_drop_occ", occ, 16);
    repeat (20) idle(1'b1);
    chk("drain_occ", occ, 0);
    chk("drain_out_valid", bus.out_valid, 0);

    // Credit violation and stickiness
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back('{mkvec(300 + k), -1});
      cycle(1'b1, mkvec(300 + k), 1'b0, '0, 1'b0);
    end
    chk("cv_issue_ok_low", bus.issue_ok, 0);
    chk("cv_err_credit_before", cred, 0);
    cycle(1'b1, mkvec(316), 1'b0, '0, 1'b0);
    chk("cv_err_credit_set", cred, 1);
    bad_cred = 1'b0;
    repeat (100) begin
      idle(1'b0);
      if (cred !== 1'b1) bad_cred = 1'b1;
    end
    chk("cv_err_credit_sticky", bad_cred, 0);
    chk("cv_occ_full", occ, 16);
    repeat (20) idle(1'b1);
    chk("cv_drain_occ", occ, 0);

    // Wrap-around on the DEPTH=5 instance with random backpressure
    sent = 0; n = 0;
    while ((sent < 23 || exp5_q.size() != 0) && n < 600) begin
      bus5.out_ready = 1'($urandom_range(0, 1));
      if (sent < 23 && occ5 < 5) begin
        bus5.in_valid = 1'b1;
        bus5.in_data  = mkvec(500 + sent);
        exp5_q.push_back('{mkvec(500 + sent), -1});
        sent++;
      end else begin
        bus5.in_valid = 1'b0;
        bus5.in_data  = '0;
      end
      @(posedge clk);
      #1;
      cyc++;
      n++;
    end
    bus5.in_valid = 1'b0;
    bus5.out_ready = 1'b0;
    chk("wrap_within_budget", (n < 600), 1);
    chk("wrap_pop_count", pops5, 23);
    chk("wrap_occ_empty", occ5, 0);
    chk("wrap_err_overflow", ovf5, 0);

    chk("sb_main_empty", exp_q.size(), 0);
    chk("adder_model_empty", pend_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
